// File: rtl/fp_mac.sv
// Single-precision streaming multiply-accumulate: P <= a*b, ACC <= ACC + P, out = ACC.
// Optional synchronous accumulator restart via `define FP_MAC_CLR_EN (adds input clr).
module fp_mac (
   input  logic        clk,
   input  logic        reset,
`ifdef FP_MAC_CLR_EN
   input  logic        clr,
`endif
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] out
);

   localparam int unsigned W  = 32;
   localparam int unsigned FW = 23;
   localparam logic [W-1:0] QNAN = 32'h7FC0_0000;

   logic [W-1:0] r_p;
   logic [W-1:0] r_acc;
   logic [W-1:0] w_prod;
   logic [W-1:0] w_sum;

   function automatic logic is_nan(input logic [W-1:0] x);
      return (&x[30:23]) && (|x[FW-1:0]);
   endfunction

   function automatic logic is_inf(input logic [W-1:0] x);
      return (&x[30:23]) && !(|x[FW-1:0]);
   endfunction

   // Exponent field 0 covers both true zeros and flushed subnormals
   function automatic logic is_zero(input logic [W-1:0] x);
      return x[30:23] == 8'd0;
   endfunction

   // RNE on a normalized 24-bit significand, then overflow/underflow clamping
   function automatic logic [W-1:0] round_pack(input logic s, input logic signed [9:0] e_in,
                                               input logic [23:0] mant, input logic g,
                                               input logic st);
      logic [24:0]       mr;
      logic signed [9:0] e;
      logic [W-1:0]      res;
      mr = {1'b0, mant} + {24'b0, g & (st | mant[0])};
      e  = mr[24] ? e_in + 10'sd1 : e_in;
      if (e >= 10'sd255)    res = {s, 8'hFF, 23'b0};
      else if (e <= 10'sd0) res = {s, 31'b0};
      else                  res = {s, e[7:0], (mr[24] ? 23'b0 : mr[22:0])};
      return res;
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] c;
      logic       found;
      c     = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && v[i]) found = 1'b1;
         else if (!found)    c = c + 5'd1;
      end
      return c;
   endfunction

   function automatic logic [W-1:0] fp_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic              s;
      logic [47:0]       prod;
      logic signed [9:0] e;
      logic [W-1:0]      res;
      s    = x[31] ^ y[31];
      prod = {1'b1, x[FW-1:0]} * {1'b1, y[FW-1:0]};
      e    = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
      if (is_nan(x) || is_nan(y))
         res = QNAN;
      else if ((is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x)))
         res = QNAN;
      else if (is_inf(x) || is_inf(y))
         res = {s, 8'hFF, 23'b0};
      else if (is_zero(x) || is_zero(y))
         res = {s, 31'b0};
      else if (prod[47])
         res = round_pack(s, e + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
      else
         res = round_pack(s, e, prod[46:23], prod[22], |prod[21:0]);
      return res;
   endfunction

   function automatic logic [W-1:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0]      big;
      logic [W-1:0]      sml;
      logic [7:0]        d;
      logic [4:0]        dc;
      logic [49:0]       w;
      logic [26:0]       m_big;
      logic [26:0]       m_sml;
      logic [27:0]       sum;
      logic [26:0]       n;
      logic [4:0]        lz;
      logic signed [9:0] e;
      logic [W-1:0]      res;
      big   = (x[30:0] >= y[30:0]) ? x : y;
      sml   = (x[30:0] >= y[30:0]) ? y : x;
      d     = big[30:23] - sml[30:23];
      dc    = (d > 8'd31) ? 5'd31 : d[4:0];
      // Significand plus guard/round bits on top, everything shifted out folds into sticky
      w     = {1'b1, sml[FW-1:0], 26'b0} >> dc;
      m_sml = {w[49:24], |w[23:0]};
      m_big = {1'b1, big[FW-1:0], 3'b0};
      sum   = (big[31] ^ sml[31]) ? {1'b0, m_big} - {1'b0, m_sml}
                                  : {1'b0, m_big} + {1'b0, m_sml};
      e     = $signed({2'b0, big[30:23]});
      n     = 27'd0;
      lz    = 5'd0;
      if (is_nan(x) || is_nan(y))
         res = QNAN;
      else if (is_inf(x) && is_inf(y))
         res = (x[31] != y[31]) ? QNAN : x;
      else if (is_inf(x))
         res = x;
      else if (is_inf(y))
         res = y;
      else if (is_zero(x) && is_zero(y))
         res = {x[31] & y[31], 31'b0};
      else if (is_zero(x))
         res = y;
      else if (is_zero(y))
         res = x;
      else if (sum == 28'd0)
         res = 32'h0000_0000;
      else if (sum[27]) begin
         n   = {sum[27:2], sum[1] | sum[0]};
         res = round_pack(big[31], e + 10'sd1, n[26:3], n[2], n[1] | n[0]);
      end else begin
         lz  = lzc27(sum[26:0]);
         n   = sum[26:0] << lz;
         res = round_pack(big[31], e - $signed({5'b0, lz}), n[26:3], n[2], n[1] | n[0]);
      end
      return res;
   endfunction

   assign w_prod = fp_mul(a, b);
   assign w_sum  = fp_add(r_acc, r_p);

   // Two-stage pipe: product register feeding the accumulator
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_p   <= '0;
         r_acc <= '0;
      end else begin
         r_p <= w_prod;
`ifdef FP_MAC_CLR_EN
         r_acc <= clr ? r_p : w_sum;
`else
         r_acc <= w_sum;
`endif
      end
   end

   assign out = r_acc;

endmodule

// File: tb/tb_fp_mac.sv
// Directed scoreboard bench for fp_mac; expected out values are queued at drive time.
module tb_fp_mac;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] out;
`ifdef FP_MAC_CLR_EN
   logic        clr;
`endif

   int unsigned n_tests;
   int unsigned n_fail;
   logic [31:0] exp_q[$];

   fp_mac dut (
      .clk   (clk),
      .reset (reset),
`ifdef FP_MAC_CLR_EN
      .clr   (clr),
`endif
      .a     (a),
      .b     (b),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_now(input string tag, input logic [31:0] expv);
      n_tests++;
      assert (out === expv) else begin
         n_fail++;
         $error("FAIL %s: out=%h expected=%h", tag, out, expv);
      end
   endtask

   // Drive operands, queue the out value expected after the next edge, then compare
   task automatic cycle(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] expv);
      logic [31:0] e;
      a = av;
      b = bv;
      exp_q.push_back(expv);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_now(tag, e);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      a = 32'h0;
      b = 32'h0;
      @(posedge clk);
      #1;
      check_now("rst_low", 32'h0);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
`ifdef FP_MAC_CLR_EN
      clr = 1'b0;
`endif
      reset = 1'b0;
      a = 32'h4040_0000;
      b = 32'h4000_0000;
      #2;
      check_now("rst_async_init", 32'h0);
      // Held in reset with live operands: nothing accumulates
      cycle("rst_hold1", 32'h4040_0000, 32'h4000_0000, 32'h0);
      cycle("rst_hold2", 32'h4040_0000, 32'h4000_0000, 32'h0);
      cycle("rst_hold3", 32'h4040_0000, 32'h4000_0000, 32'h0);

      // 3.0 * 2.0 held from release
      reset = 1'b1;
      cycle("acc_e1", 32'h4040_0000, 32'h4000_0000, 32'h0000_0000);
      cycle("acc_e2", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
      cycle("acc_e3", 32'h4040_0000, 32'h4000_0000, 32'h4140_0000);
      cycle("acc_e4", 32'h4040_0000, 32'h4000_0000, 32'h4190_0000);

      // Async reset pulse mid-accumulation
      do_reset();
      cycle("pulse_e1", 32'h4040_0000, 32'h4000_0000, 32'h0000_0000);
      cycle("pulse_e2", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
      cycle("pulse_e3", 32'h4040_0000, 32'h4000_0000, 32'h4140_0000);
      #2;
      reset = 1'b0;
      #1;
      check_now("pulse_async_clear", 32'h0);
      reset = 1'b1;
      cycle("pulse_after1", 32'h4040_0000, 32'h4000_0000, 32'h0000_0000);
      cycle("pulse_after2", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);

      // Normal product with a near-minimum operand
      do_reset();
      cycle("norm_e1", 32'h40DD_0000, 32'h00DD_0000, 32'h0000_0000);
      cycle("norm_e2", 32'h0000_0000, 32'h0000_0000, 32'h023E_C900);
      cycle("norm_e3", 32'h0000_0000, 32'h0000_0000, 32'h023E_C900);

      // Exact cancellation yields +0
      do_reset();
      cycle("cancel_e1", 32'h4040_0000, 32'h4000_0000, 32'h0000_0000);
      cycle("cancel_e2", 32'hC040_0000, 32'h4000_0000, 32'h40C0_0000);
      cycle("cancel_e3", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
      cycle("cancel_e4", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

      // Product below 2^-126 flushes
      do_reset();
      cycle("ftz_e1", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
      cycle("ftz_e2", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
      cycle("ftz_e3", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

      // Multiply overflow, sticky inf, then inf + -inf
      do_reset();
      cycle("ovf_e1", 32'h7F00_0000, 32'h4000_0000, 32'h0000_0000);
      cycle("ovf_e2", 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000);
      cycle("ovf_e3", 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000);
      cycle("ovf_e4", 32'hFF80_0000, 32'h3F80_0000, 32'h7F80_0000);
      cycle("nan_e5", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
      cycle("nan_e6", 32'h4040_0000, 32'h4000_0000, 32'h7FC0_0000);

      // Add overflow: max + max
      do_reset();
      cycle("addovf_e1", 32'h7F7F_FFFF, 32'h3F80_0000, 32'h0000_0000);
      cycle("addovf_e2", 32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF);
      cycle("addovf_e3", 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000);

      // Adder ties: 2^24+1 -> 2^24, 2^24+3 -> 2^24+4
      do_reset();
      cycle("tie_e1", 32'h4B80_0000, 32'h3F80_0000, 32'h0000_0000);
      cycle("tie_e2", 32'h3F80_0000, 32'h3F80_0000, 32'h4B80_0000);
      cycle("tie_e3", 32'h4040_0000, 32'h3F80_0000, 32'h4B80_0000);
      cycle("tie_e4", 32'h0000_0000, 32'h0000_0000, 32'h4B80_0002);

      // Multiplier normalization with carry into bit 47
      do_reset();
      cycle("mulnorm_e1", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0000);
      cycle("mulnorm_e2", 32'h0000_0000, 32'h0000_0000, 32'h407F_FFFE);

      // inf * 0 and NaN operand produce canonical NaN
      do_reset();
      cycle("infz_e1", 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000);
      cycle("infz_e2", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
      do_reset();
      cycle("nanin_e1", 32'h7F80_0001, 32'h3F80_0000, 32'h0000_0000);
      cycle("nanin_e2", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);

`ifdef FP_MAC_CLR_EN
      // Restart the sum from the in-flight product
      do_reset();
      cycle("clr_e1", 32'h4040_0000, 32'h4000_0000, 32'h0000_0000);
      cycle("clr_e2", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
      cycle("clr_e3", 32'h4040_0000, 32'h4000_0000, 32'h4140_0000);
      clr = 1'b1;
      cycle("clr_e4", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
      clr = 1'b0;
      cycle("clr_e5", 32'h4040_0000, 32'h4000_0000, 32'h4140_0000);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
